seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter SCAN_LOG2, default 16: log2 of clk cycles per digit slot, legal range 4..20.
REQ-003 Parameter BRIGHT_W, default 4: brightness code width, legal range 1..SCAN_LOG2-1.
REQ-004 Parameter DEAD_CYC, default 64: anode-off guard cycles at slot start, legal range 0..2^SCAN_LOG2-1.
REQ-005 clk  in  1: single clock; all logic on the rising edge.
REQ-006 rst_n  in  1: synchronous, active-low reset.
REQ-007 digits_in  in  4*NUM_DIGITS: hex nibble per digit; digit i is bits [4i+3:4i]; digit 0 is rightmost.
REQ-008 dp_mask  in  NUM_DIGITS: 1 lights the decimal point of digit i.
REQ-009 blink_mask  in  NUM_DIGITS: 1 makes digit i blink.
REQ-010 blink_phase  in  1: blink clock; 1 means blinking digits are dark.
REQ-011 lz_en  in  1: 1 enables leading-zero suppression.
REQ-012 brightness  in  BRIGHT_W: duty code; 0 means dark.
REQ-013 seg_out  out  8: {dp,g,f,e,d,c,b,a}, active-low.
REQ-014 an_out  out  NUM_DIGITS: digit enables, active-low, at most one bit low.
REQ-015 frame_done  out  1: one-cycle pulse on the last cycle of each frame.

Function
REQ-016 Slot counter slot_cnt (SCAN_LOG2 bits) shall increment every cycle; when it wraps, digit index dig shall advance 0,1,..,NUM_DIGITS-1,0.
REQ-017 frame_done shall be 1 exactly when dig = NUM_DIGITS-1 and slot_cnt is all-ones.
REQ-018 digits_in, dp_mask, blink_mask, lz_en and brightness shall be captured into shadow registers on the frame_done cycle only; mid-frame input changes shall not be displayed.
REQ-019 blink_phase shall be used live, not shadowed.
REQ-020 Digit i shall be lit when all hold: slot_cnt >= DEAD_CYC; slot_cnt[SCAN_LOG2-1 -: BRIGHT_W] < shadow brightness; not (blink_mask[i] and blink_phase); not leading-zero suppressed.
REQ-021 The maximum brightness code shall give a duty of (2^BRIGHT_W-1)/2^BRIGHT_W, less the guard time.
REQ-022 Leading-zero suppression: with lz_en=1, digit i>0 shall be suppressed when it and all higher digits are 0. Digit 0 shall never be suppressed.
REQ-023 A suppressed digit shall also suppress its dp.
REQ-024 When digit i is lit, an_out[i]=0, all other an_out bits shall be 1, and seg_out shall be the active-low hex glyph (0-F) of its nibble, with dp=~dp_mask[i].
REQ-025 When no digit is lit, an_out and seg_out shall be all 1s.
REQ-026 seg_out and an_out shall be registered: exactly 1 cycle latency from slot_cnt/dig.
REQ-027 Output changes between digits shall go through an all-anodes-off cycle whenever DEAD_CYC >= 1.

Reset
REQ-028 With rst_n=0 at a clk edge: slot_cnt=0, dig=0, all shadow registers=0, an_out all 1s, seg_out=8'hFF, frame_done=0.
REQ-029 Reset asserted mid-frame shall abort the frame without a frame_done pulse.
REQ-030 Because shadow brightness resets to 0, the display shall stay dark until the first frame_done.

Structure
REQ-031 Package seg_pkg shall hold the 16-entry active-low glyph constant table, a decode function, and the seg_t (8-bit) typedef.
REQ-032 Leading-zero masking shall be one combinational sub-module, lz_blank, parameterised on NUM_DIGITS.
REQ-033 Counters, shadows and output registers shall stay in seg_scan_ctrl.

Verification
All scenarios use NUM_DIGITS=4, SCAN_LOG2=4, BRIGHT_W=2, DEAD_CYC=2; the frame is 64 cycles.
REQ-034 Reset release, digits_in=16'h1234, brightness=3 -> dark for 64 cycles and frame_done at cycle 63; in the next frame each slot is lit on slot_cnt 2..11 (glyph offsets 3..12) with an_out 1110,1101,1011,0111 and glyphs 4,3,2,1.
REQ-035 digits_in=16'h00A0, lz_en=1 -> digits 3 and 2 stay dark; digits 1 (A) and 0 (0) are shown. digits_in=16'h0000 -> only digit 0 shows 0.
REQ-036 digits_in changed at cycle 20 of a frame -> the old value is displayed until the frame_done cycle; the new value is shown from the next frame.
REQ-037 blink_mask=4'b0011, blink_phase toggled mid-slot -> digits 0 and 1 go dark within 1 cycle; digits 2 and 3 are unaffected.
REQ-038 brightness=1 -> each slot is lit only on slot_cnt 2..3; brightness=0 -> an_out stays 1111 for a whole frame.
REQ-039 rst_n pulsed low at cycle 30 -> next cycle outputs are all 1s, dig=0, and no frame_done occurs until 64 cycles after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and the hex glyph table for the multiplexed seven-segment scanner.
// Glyphs are active-low {dp,g,f,e,d,c,b,a}; the decimal point is left off (1) here.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t GLYPH_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
        8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
        8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
        8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
    };

    function automatic seg_t seg_decode(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/lz_blank.sv
// Leading-zero masking: flags every digit above digit 0 that is zero together
// with all digits above it. Digit 0 is never flagged so a value of zero still shows.
module lz_blank #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   suppress
);

    logic zero_run;

    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (digits[4*i +: 4] == 4'h0);
            suppress[i] = lz_en && zero_run;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-frame input shadowing,
// PWM brightness, blinking, leading-zero blanking and an anode-off guard per slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_LOG2  = 16,
    parameter int BRIGHT_W   = 4,
    parameter int DEAD_CYC   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blink_phase,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output seg_t                    seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIG_W-1:0]     DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_LOG2-1:0] DEAD_SLOT = SCAN_LOG2'(DEAD_CYC);

    logic [SCAN_LOG2-1:0]    slot_cnt;
    logic [DIG_W-1:0]        dig;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz_en;
    logic [BRIGHT_W-1:0]     sh_bright;

    logic [NUM_DIGITS-1:0]   lz_sup;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_sup;
    logic                    lit;
    seg_t                    glyph;
    seg_t                    seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    lz_blank #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_blank (
        .digits   (sh_digits),
        .lz_en    (sh_lz_en),
        .suppress (lz_sup)
    );

    assign frame_done = (dig == DIG_LAST) && (&slot_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig      <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (&slot_cnt) begin
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end
        end
    end

    // Shadows only move at the frame boundary so a frame is never shown half-updated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            sh_lz_en  <= 1'b0;
            sh_bright <= '0;
        end else if (frame_done) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_mask;
            sh_blink  <= blink_mask;
            sh_lz_en  <= lz_en;
            sh_bright <= brightness;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_sup   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig == DIG_W'(i)) begin
                cur_nib   = sh_digits[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blink = sh_blink[i];
                cur_sup   = lz_sup[i];
            end
        end

        // blink_phase is deliberately live so blinking reacts within one cycle.
        lit = (slot_cnt >= DEAD_SLOT)
           && (slot_cnt[SCAN_LOG2-1 -: BRIGHT_W] < sh_bright)
           && !(cur_blink && blink_phase)
           && !cur_sup;

        glyph    = seg_decode(cur_nib);
        seg_next = lit ? {~cur_dp, glyph[6:0]} : 8'hFF;
        an_next  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (dig == DIG_W'(i))) begin
                an_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out <= 8'hFF;
            an_out  <= '1;
        end else begin
            seg_out <= seg_next;
            an_out  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at 4 digits, 16-cycle slots, 2-bit brightness, 2 guard cycles.
// An independent cycle model pushes expected outputs; a negedge checker pops and compares.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SL = 4;
    localparam int BW = 2;
    localparam int DC = 2;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits_in;
    logic [3:0]    dp_mask;
    logic [3:0]    blink_mask;
    logic          blink_phase;
    logic          lz_en;
    logic [1:0]    brightness;
    logic [7:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] exp_q[$];

    int          m_slot = 0;
    int          m_dig = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blink = '0;
    logic        m_lz = 1'b0;
    logic [1:0]  m_bright = '0;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_LOG2  (SL),
        .BRIGHT_W   (BW),
        .DEAD_CYC   (DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .blink_phase (blink_phase),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected {frame_done, an_out, seg_out} after the coming edge, from the pre-edge state.
    function automatic logic [12:0] model_out(input int slot, input int d, input logic [15:0] digs,
                                              input logic [3:0] dpm, input logic [3:0] blm,
                                              input logic lz, input logic [1:0] br, input logic ph);
        logic [15:0] hi;
        logic [3:0]  nib;
        logic [3:0]  an;
        logic [7:0]  g;
        logic [7:0]  seg;
        logic        sup;
        logic        lit;
        int          ns;
        int          nd;
        hi  = digs >> (4 * d);
        nib = hi[3:0];
        sup = lz && (d > 0) && (hi == 16'h0);
        lit = (slot >= DC) && ((slot / 4) < int'(br)) && !(blm[d] && ph) && !sup;
        an  = lit ? ~(4'b0001 << d) : 4'hF;
        g   = GLYPH[nib];
        seg = lit ? {~dpm[d], g[6:0]} : 8'hFF;
        ns  = (slot + 1) % 16;
        nd  = (slot == 15) ? (d + 1) % ND : d;
        return {(nd == ND - 1) && (ns == 15), an, seg};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
            m_slot   <= 0;
            m_dig    <= 0;
            m_digits <= '0;
            m_dp     <= '0;
            m_blink  <= '0;
            m_lz     <= 1'b0;
            m_bright <= '0;
        end else begin
            exp_q.push_back(model_out(m_slot, m_dig, m_digits, m_dp, m_blink, m_lz, m_bright, blink_phase));
            if (m_slot == 15 && m_dig == ND - 1) begin
                m_digits <= digits_in;
                m_dp     <= dp_mask;
                m_blink  <= blink_mask;
                m_lz     <= lz_en;
                m_bright <= brightness;
            end
            m_slot <= (m_slot + 1) % 16;
            if (m_slot == 15) m_dig <= (m_dig + 1) % ND;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic logic [12:0] e = exp_q.pop_front();
            chk("frame_done", 32'(frame_done), 32'(e[12]));
            chk("an_out", 32'(an_out), 32'(e[11:8]));
            chk("seg_out", 32'(seg_out), 32'(e[7:0]));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs one aligned frame, counting lit cycles and which anodes were driven.
    task automatic count_frame(output int lit, output logic [3:0] seen);
        lit  = 0;
        seen = 4'h0;
        repeat (64) begin
            @(negedge clk);
            if (an_out != 4'hF) lit++;
            seen = seen | ~an_out;
        end
    endtask

    task automatic wait_fd();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        if (k == 200) chk("fd_timeout", 32'd0, 32'd1);
    endtask

    // After a reset release: cycles until frame_done, counting the slot-0 cycle as cycle 0.
    task automatic first_fd(output int cyc, output int lit);
        cyc = -1;
        lit = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (an_out != 4'hF) lit++;
            if (frame_done) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    initial begin
        int         lit;
        int         cyc;
        logic [3:0] seen;

        rst_n       = 1'b0;
        digits_in   = 16'h1234;
        dp_mask     = 4'h0;
        blink_mask  = 4'h0;
        blink_phase = 1'b0;
        lz_en       = 1'b0;
        brightness  = 2'd3;
        cycles(3);
        chk("reset_an", 32'(an_out), 32'hF);
        chk("reset_seg", 32'(seg_out), 32'hFF);
        rst_n = 1'b1;

        first_fd(cyc, lit);
        chk("first_fd_cycle", 32'(cyc), 32'd63);
        chk("dark_first_frame", 32'(lit), 32'd0);
        count_frame(lit, seen);
        chk("lit_bright3", 32'(lit), 32'd40);
        chk("anodes_bright3", 32'(seen), 32'hF);

        digits_in = 16'h00A0;
        lz_en     = 1'b1;
        dp_mask   = 4'b1111;
        count_frame(lit, seen);
        chk("lz_00a0_lit", 32'(lit), 32'd20);
        chk("lz_00a0_anodes", 32'(seen), 32'h3);
        digits_in = 16'h0000;
        count_frame(lit, seen);
        chk("lz_0000_lit", 32'(lit), 32'd10);
        chk("lz_0000_anodes", 32'(seen), 32'h1);

        digits_in = 16'h5678;
        lz_en     = 1'b0;
        dp_mask   = 4'b0101;
        count_frame(lit, seen);
        cycles(20);
        digits_in = 16'h9ABC;
        cycles(44);
        chk("fd_aligned", 32'(frame_done), 32'd1);
        count_frame(lit, seen);

        digits_in  = 16'h1234;
        blink_mask = 4'b0011;
        count_frame(lit, seen);
        for (int t = 0; t < 128; t += 0) begin
            automatic int step = $urandom_range(1, 7);
            cycles(step);
            t += step;
            blink_phase = ~blink_phase;
        end
        blink_phase = 1'b1;
        wait_fd();
        count_frame(lit, seen);
        chk("blink_anodes", 32'(seen), 32'hC);
        chk("blink_lit", 32'(lit), 32'd20);
        blink_phase = 1'b0;
        blink_mask  = 4'b0000;

        brightness = 2'd1;
        count_frame(lit, seen);
        count_frame(lit, seen);
        chk("lit_bright1", 32'(lit), 32'd8);
        brightness = 2'd0;
        count_frame(lit, seen);
        count_frame(lit, seen);
        chk("lit_bright0", 32'(lit), 32'd0);

        brightness = 2'd3;
        count_frame(lit, seen);
        cycles(30);
        rst_n = 1'b0;
        cycles(1);
        chk("midreset_an", 32'(an_out), 32'hF);
        chk("midreset_seg", 32'(seg_out), 32'hFF);
        chk("midreset_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        first_fd(cyc, lit);
        chk("post_reset_fd_cycle", 32'(cyc), 32'd63);
        chk("post_reset_dark", 32'(lit), 32'd0);

        for (int f = 0; f < 4; f++) begin
            digits_in   = 16'($urandom_range(0, 16'hFFFF));
            dp_mask     = 4'($urandom_range(0, 15));
            blink_mask  = 4'($urandom_range(0, 15));
            lz_en       = 1'($urandom_range(0, 1));
            brightness  = 2'($urandom_range(0, 3));
            blink_phase = 1'($urandom_range(0, 1));
            count_frame(lit, seen);
        end

        cycles(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
